// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } dmem_state_t;

    localparam int unsigned DMEM_CNT_W = 4;

    function automatic int unsigned dmem_index_w(input int unsigned depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Core-side data-memory port: byte address, store data, read/write requests, load data, stall, error.
interface dmem_if;
    logic [31:0] d_mem_w_addr;
    logic [31:0] d_mem_w_data;
    logic        d_mem_we;
    logic        d_mem_oe;
    logic [31:0] d_mem_r_data;
    logic        d_mem_stall;
    logic        d_mem_err;

    modport master (
        output d_mem_w_addr, d_mem_w_data, d_mem_we, d_mem_oe,
        input  d_mem_r_data, d_mem_stall, d_mem_err
    );

    modport slave (
        input  d_mem_w_addr, d_mem_w_data, d_mem_we, d_mem_oe,
        output d_mem_r_data, d_mem_stall, d_mem_err
    );
endinterface

// File: rtl/dmem_array.sv
// Single-port synchronous word RAM with a registered, resettable read port.
// Contents are never cleared; writes are blocked while rst is low.
module dmem_array
    import dmem_pkg::*;
#(
    parameter  int unsigned DEPTH = 1024,
    localparam int unsigned AW    = dmem_index_w(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic          re,
    input  logic          zero,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH];
    logic [31:0] rdata_d;
    logic [31:0] rdata_q;

    always_ff @(posedge clk) begin
        if (rst && we) begin
            mem[addr] <= wdata;
        end
    end

    // zero forces a blank word for reads the responder has flagged as out of range
    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
            rdata_d = zero ? 32'h0 : mem[addr];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rdata_q <= 32'h0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: single-cycle writes, LATENCY-cycle reads with pipeline stall.
// Build option DMEM_ERR_CHECK_EN enables misaligned/out-of-range detection and the sticky error flag.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH   = 1024,
    parameter int unsigned LATENCY = 2
) (
    input logic   clk,
    input logic   rst,
    dmem_if.slave bus
);

    localparam int unsigned           IW       = dmem_index_w(DEPTH);
    localparam logic [DMEM_CNT_W-1:0] CNT_INIT = DMEM_CNT_W'(LATENCY - 1);

    dmem_state_t           state_q, state_d;
    logic [DMEM_CNT_W-1:0] cnt_q, cnt_d;
    logic [IW-1:0]         addr_q, addr_d;
    logic                  zero_q, zero_d;
    logic                  err_q, err_d;

    logic [IW-1:0] live_idx_c;
    logic          oor_c;
    logic          bad_c;
    logic          arr_we_c, arr_re_c, arr_zero_c;
    logic [IW-1:0] arr_addr_c;
    logic [31:0]   r_data_c;

    assign live_idx_c = bus.d_mem_w_addr[IW+1:2];

`ifdef DMEM_ERR_CHECK_EN
    assign oor_c = |bus.d_mem_w_addr[31:IW+2];
    assign bad_c = oor_c || (|bus.d_mem_w_addr[1:0]);
`else
    // Without checking, the high and byte-lane bits are simply dropped so addresses alias.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{bus.d_mem_w_addr[31:IW+2], bus.d_mem_w_addr[1:0]};
    assign oor_c = 1'b0;
    assign bad_c = 1'b0;
`endif

    // Next-state, counter and array control
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        zero_d     = zero_q;
        err_d      = err_q;
        arr_we_c   = 1'b0;
        arr_re_c   = 1'b0;
        arr_zero_c = 1'b0;
        arr_addr_c = live_idx_c;

        case (state_q)
            IDLE: begin
                if (bus.d_mem_we) begin
                    arr_we_c = !oor_c;
                    err_d    = err_q || bad_c;
                end else if (bus.d_mem_oe) begin
                    addr_d = live_idx_c;
                    zero_d = oor_c;
                    cnt_d  = CNT_INIT;
                    err_d  = err_q || bad_c;
                    if (LATENCY == 1) begin
                        arr_re_c   = 1'b1;
                        arr_zero_c = oor_c;
                        state_d    = DONE;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                cnt_d      = cnt_q - DMEM_CNT_W'(1);
                arr_addr_c = addr_q;
                if (cnt_d == '0) begin
                    arr_re_c   = 1'b1;
                    arr_zero_c = zero_q;
                    state_d    = DONE;
                end
            end
            DONE: begin
                if (bus.d_mem_we) begin
                    arr_we_c = !oor_c;
                    err_d    = err_q || bad_c;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            zero_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            zero_q  <= zero_d;
            err_q   <= err_d;
        end
    end

    dmem_array #(.DEPTH(DEPTH)) u_array (
        .clk   (clk),
        .rst   (rst),
        .we    (arr_we_c),
        .re    (arr_re_c),
        .zero  (arr_zero_c),
        .addr  (arr_addr_c),
        .wdata (bus.d_mem_w_data),
        .rdata (r_data_c)
    );

    // Stall follows the request combinationally so the core freezes in the accept cycle.
    assign bus.d_mem_stall  = rst && (((state_q == IDLE) && bus.d_mem_oe && !bus.d_mem_we)
                                      || (state_q == WAIT));
    assign bus.d_mem_r_data = r_data_c;
    assign bus.d_mem_err    = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized bench for dmem_responder against a word-array reference model.
module tb_dmem_responder;
    import dmem_pkg::*;

    localparam int unsigned DEPTH = 1024;
    localparam int unsigned LAT   = 2;
`ifdef DMEM_ERR_CHECK_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dmem_if dif ();
    dmem_if dif1 ();

    dmem_responder #(.DEPTH(DEPTH), .LATENCY(LAT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (dif.slave)
    );

    dmem_responder #(.DEPTH(DEPTH), .LATENCY(1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (dif1.slave)
    );

    logic [31:0] ref_mem [DEPTH];
    logic        ref_err;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic bit is_oor(input logic [31:0] a);
        return ERR_EN && (a >= 32'(4 * DEPTH));
    endfunction

    function automatic bit is_bad(input logic [31:0] a);
        return ERR_EN && (is_oor(a) || (a % 4 != 0));
    endfunction

    function automatic int idx(input logic [31:0] a);
        return int'((a / 4) % DEPTH);
    endfunction

    task automatic ref_write(input logic [31:0] a, input logic [31:0] d);
        if (!is_oor(a)) ref_mem[idx(a)] = d;
        if (is_bad(a)) ref_err = 1'b1;
    endtask

    function automatic logic [31:0] rand_addr();
        return 32'($urandom_range(DEPTH - 1, 0)) * 4;
    endfunction

    function automatic logic [31:0] rand_any_addr();
        case ($urandom_range(3, 0))
            0:       return rand_addr();
            1:       return rand_addr() | 32'($urandom_range(3, 1));
            2:       return rand_addr() | (32'($urandom_range(1000, 1)) << 12);
            default: return $urandom;
        endcase
    endfunction

    task automatic set_idle();
        dif.d_mem_we = 1'b0;
        dif.d_mem_oe = 1'b0;
    endtask

    // Enter and leave at posedge+1 with the responder idle.
    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input bit with_oe);
        dif.d_mem_w_addr = a;
        dif.d_mem_w_data = d;
        dif.d_mem_we     = 1'b1;
        dif.d_mem_oe     = with_oe;
        #1 chk("wr_stall", 32'(dif.d_mem_stall), 32'h0);
        ref_write(a, d);
        @(posedge clk); #1;
        set_idle();
        chk("wr_err", 32'(dif.d_mem_err), 32'(ref_err));
    endtask

    task automatic do_read(input logic [31:0] a, input bit done_wr, input bit scramble);
        logic [31:0] exp;
        logic [31:0] wa;
        logic [31:0] wd;
        exp = is_oor(a) ? 32'h0 : ref_mem[idx(a)];
        if (is_bad(a)) ref_err = 1'b1;
        dif.d_mem_w_addr = a;
        dif.d_mem_we     = 1'b0;
        dif.d_mem_oe     = 1'b1;
        for (int i = 0; i < int'(LAT); i++) begin
            #1 chk("rd_stall_hi", 32'(dif.d_mem_stall), 32'h1);
            @(posedge clk); #1;
            if (scramble && i < int'(LAT) - 1) begin
                dif.d_mem_w_addr = $urandom;
                dif.d_mem_w_data = $urandom;
                dif.d_mem_we     = 1'($urandom);
                dif.d_mem_oe     = 1'($urandom);
            end
        end
        chk("rd_stall_lo", 32'(dif.d_mem_stall), 32'h0);
        chk("rd_data", dif.d_mem_r_data, exp);
        dif.d_mem_oe = 1'($urandom);
        if (done_wr) begin
            wa = rand_addr();
            wd = $urandom;
            dif.d_mem_w_addr = wa;
            dif.d_mem_w_data = wd;
            dif.d_mem_we     = 1'b1;
            ref_write(wa, wd);
        end else begin
            dif.d_mem_w_addr = $urandom;
            dif.d_mem_we     = 1'b0;
        end
        @(posedge clk); #1;
        set_idle();
        chk("rd_err", 32'(dif.d_mem_err), 32'(ref_err));
        chk("rd_hold", dif.d_mem_r_data, exp);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        ref_err = 1'b0;
        chk("rst_err", 32'(dif.d_mem_err), 32'h0);
        chk("rst_stall", 32'(dif.d_mem_stall), 32'h0);
        chk("rst_rdata", dif.d_mem_r_data, 32'h0);
    endtask

    initial begin
        logic [31:0] a;
        int          c0;
        int          op;

        rst = 1'b0;
        ref_err = 1'b0;
        dif.d_mem_w_addr  = '0; dif.d_mem_w_data  = '0; set_idle();
        dif1.d_mem_w_addr = '0; dif1.d_mem_w_data = '0; dif1.d_mem_we = 1'b0; dif1.d_mem_oe = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        chk("init_rdata", dif.d_mem_r_data, 32'h0);
        chk("init_stall", 32'(dif.d_mem_stall), 32'h0);
        chk("init_err", 32'(dif.d_mem_err), 32'h0);

        for (int i = 0; i < int'(DEPTH); i++) begin
            dif.d_mem_w_addr = 32'(i) * 4;
            dif.d_mem_w_data = $urandom;
            dif.d_mem_we     = 1'b1;
            ref_mem[i]       = dif.d_mem_w_data;
            @(posedge clk); #1;
        end
        set_idle();

        do_write(32'h10, 32'hDEADBEEF, 1'b0);
        do_read(32'h10, 1'b0, 1'b0);

        do_write(32'h20, 32'hA5A5A5A5, 1'b1);
        do_read(32'h20, 1'b0, 1'b1);

        do_write(32'h4, 32'h1, 1'b0);
        do_write(32'h8, 32'h2, 1'b0);
        c0 = cyc;
        do_read(32'h4, 1'b0, 1'b0);
        do_read(32'h8, 1'b0, 1'b0);
        chk("b2b_cycles", 32'(cyc - c0), 32'(2 * (LAT + 1)));

        for (int n = 0; n < 300; n++) begin
            op = int'($urandom_range(2, 0));
            if (op == 0)      do_write(rand_addr(), $urandom, 1'($urandom));
            else              do_read(rand_addr(), 1'($urandom), 1'($urandom));
        end

        do_read(32'h2, 1'b0, 1'b0);
        chk("misalign_err", 32'(dif.d_mem_err), 32'(ERR_EN));

        do_reset();
        do_write(32'h1000, 32'hCAFEF00D, 1'b0);
        chk("oor_wr_err", 32'(dif.d_mem_err), 32'(ERR_EN));
        do_read(32'h0, 1'b0, 1'b0);

        for (int n = 0; n < 4; n++) begin
            do_reset();
            for (int k = 0; k < 25; k++) begin
                a = rand_any_addr();
                if ($urandom_range(1, 0) == 0) do_write(a, $urandom, 1'b0);
                else                           do_read(a, 1'($urandom), 1'($urandom));
            end
        end

        do_reset();
        dif.d_mem_w_addr = 32'h40;
        dif.d_mem_oe     = 1'b1;
        #1 chk("mid_stall0", 32'(dif.d_mem_stall), 32'h1);
        @(posedge clk); #1;
        rst = 1'b0;
        dif.d_mem_w_addr = 32'h44;
        dif.d_mem_w_data = ~ref_mem[17];
        dif.d_mem_we     = 1'b1;
        @(posedge clk); #1;
        chk("mid_stall", 32'(dif.d_mem_stall), 32'h0);
        chk("mid_rdata", dif.d_mem_r_data, 32'h0);
        rst = 1'b1;
        set_idle();
        do_read(32'h44, 1'b0, 1'b0);
        do_read(32'h40, 1'b0, 1'b0);

        dif1.d_mem_w_addr = 32'h0;
        dif1.d_mem_w_data = 32'h12345678;
        dif1.d_mem_we     = 1'b1;
        @(posedge clk); #1;
        dif1.d_mem_w_addr = 32'h44;
        dif1.d_mem_w_data = 32'h0BADF00D;
        @(posedge clk); #1;
        dif1.d_mem_we = 1'b0;
        for (int k = 0; k < 2; k++) begin
            dif1.d_mem_w_addr = (k == 0) ? 32'h0 : 32'h44;
            dif1.d_mem_oe     = 1'b1;
            #1 chk("l1_stall_hi", 32'(dif1.d_mem_stall), 32'h1);
            @(posedge clk); #1;
            chk("l1_stall_lo", 32'(dif1.d_mem_stall), 32'h0);
            chk("l1_rdata", dif1.d_mem_r_data, (k == 0) ? 32'h12345678 : 32'h0BADF00D);
            dif1.d_mem_oe = 1'b0;
            @(posedge clk); #1;
            chk("l1_hold", dif1.d_mem_r_data, (k == 0) ? 32'h12345678 : 32'h0BADF00D);
        end
        chk("l1_err", 32'(dif1.d_mem_err), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
